freq_count_core: RTL

//  Measurement engine behind the Frequency_counter_AXI4 register slave. Counts rising edges of an

---
 rtl/freq_counter_pkg.sv | 14 +
 rtl/fc_sync_edge.sv | 38 +++
 rtl/freq_count_core.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/freq_counter_pkg.sv
// rtl/freq_counter_pkg.sv - shared state encoding and default widths for the frequency counter
package freq_counter_pkg;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_ARM  = 2'd1,
        FC_GATE = 2'd2
    } fc_state_e;

    localparam int FC_SYNC_STAGES = 2;
    localparam int FC_GATE_WIDTH  = 32;
    localparam int FC_COUNT_WIDTH = 32;

endpackage

// File: rtl/fc_sync_edge.sv
// rtl/fc_sync_edge.sv - multi-flop synchroniser with registered rising-edge pulse
module fc_sync_edge
    import freq_counter_pkg::*;
#(
    parameter int SYNC_STAGES = FC_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
        // Registered compare adds one cycle: pulse lands SYNC_STAGES+1 cycles after the edge.
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/freq_count_core.sv
// rtl/freq_count_core.sv - gated edge counter core; FREQ_COUNTER_IRQ_EN adds a sticky result interrupt
module freq_count_core
    import freq_counter_pkg::*;
#(
    parameter int SYNC_STAGES = FC_SYNC_STAGES,
    parameter int GATE_WIDTH  = FC_GATE_WIDTH,
    parameter int COUNT_WIDTH = FC_COUNT_WIDTH
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   sig_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [GATE_WIDTH-1:0]  gate_cycles,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   count_valid,
    output logic                   overflow,
    output logic                   busy,
    output logic                   irq,
    input  logic                   irq_clr
);

    fc_state_e              state_q, state_d;
    logic [GATE_WIDTH-1:0]  timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;

    logic                   rise;
    logic                   sat_now;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic [GATE_WIDTH-1:0]  load_val;

    fc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (ACLK),
        .rst_n_i (ARESETN),
        .async_i (sig_in),
        .rise_o  (rise)
    );

    always_comb begin
        sat_now  = rise && (edge_cnt_q == '1);
        cnt_inc  = sat_now ? edge_cnt_q : edge_cnt_q + COUNT_WIDTH'(rise);
        // A zero gate length is run as a one-cycle window.
        load_val = (gate_cycles == '0) ? '0 : gate_cycles - GATE_WIDTH'(1);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            FC_IDLE: begin
                if (start && !abort) begin
                    state_d    = FC_ARM;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end
            end
            FC_ARM: begin
                if (abort) begin
                    state_d = FC_IDLE;
                end else if (rise) begin
                    // The aligning edge only opens the window; it is not counted.
                    state_d    = FC_GATE;
                    timer_d    = load_val;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end
            end
            FC_GATE: begin
                if (abort) begin
                    state_d = FC_IDLE;
                end else if (timer_q == '0) begin
                    count_d    = cnt_inc;
                    overflow_d = ovf_acc_q | sat_now;
                    valid_d    = 1'b1;
                    if (continuous) begin
                        timer_d    = load_val;
                        edge_cnt_d = '0;
                        ovf_acc_d  = 1'b0;
                    end else begin
                        state_d = FC_IDLE;
                    end
                end else begin
                    edge_cnt_d = cnt_inc;
                    ovf_acc_d  = ovf_acc_q | sat_now;
                    timer_d    = timer_q - GATE_WIDTH'(1);
                end
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= FC_IDLE;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count_out   = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != FC_IDLE);

`ifdef FREQ_COUNTER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        // A new result beats a simultaneous clear.
        if (valid_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
